// File: rtl/fb_fill_engine.sv
// -----------------------------------------------------------------------------
// fb_fill_engine
//
// Purpose:
//   Framebuffer / Z-buffer fill engine. Writes a latched fill value either over
//   the whole frame or over a clamped, inclusive rectangle. Addresses are
//   linear, row-major: y*H_RES + x. The engine honours a memory-ready stall,
//   uses a start/busy/done handshake and flags invalid rectangles with err.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous, active-high reset
//   start       in   one-cycle request, sampled only when idle
//   mode        in   0 = full-frame clear, 1 = rectangle fill
//   x0, y0      in   rectangle top-left corner (inclusive)
//   x1, y1      in   rectangle bottom-right corner (inclusive)
//   fill_color  in   fill value, channel 0 in the LSBs
//   mem_ready   in   memory accepts a write this cycle when high
//   addr        out  write address
//   wdata       out  write data
//   we          out  write strobe
//   busy        out  high from the cycle after start is accepted until done
//   done        out  one-cycle completion pulse
//   err         out  one-cycle pulse with done when the rectangle is invalid
// -----------------------------------------------------------------------------
module fb_fill_engine #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int ADDR_W  = 19,
    parameter int N_CH    = 3,
    parameter int CH_BITS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      mode,
    input  logic [X_W-1:0]            x0,
    input  logic [Y_W-1:0]            y0,
    input  logic [X_W-1:0]            x1,
    input  logic [Y_W-1:0]            y1,
    input  logic [N_CH*CH_BITS-1:0]   fill_color,
    input  logic                      mem_ready,
    output logic [ADDR_W-1:0]         addr,
    output logic [N_CH*CH_BITS-1:0]   wdata,
    output logic                      we,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int PIX_W = N_CH * CH_BITS;

    localparam logic [X_W-1:0]    X_MAX  = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]    Y_MAX  = Y_W'(V_RES - 1);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        FILL,
        FIN
    } state_t;

    state_t              state_q;

    // Latched request
    logic [X_W-1:0]      x0_q;
    logic [Y_W-1:0]      y0_q;
    logic [X_W-1:0]      x1_q;
    logic [Y_W-1:0]      y1_q;
    logic [PIX_W-1:0]    color_q;

    // Cursor and running row offset
    logic [X_W-1:0]      cx_q;
    logic [Y_W-1:0]      cy_q;
    logic [ADDR_W-1:0]   row_base_q;

    // Registered outputs
    logic [ADDR_W-1:0]   addr_q;
    logic [PIX_W-1:0]    wdata_q;
    logic                we_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    // Combinational helpers
    logic [X_W-1:0]      x1_clamp_d;
    logic [Y_W-1:0]      y1_clamp_d;
    logic                rect_bad_d;
    logic [ADDR_W-1:0]   row_base_d;
    logic [ADDR_W-1:0]   next_row_d;
    logic                accept_d;
    logic                last_col_d;
    logic                last_row_d;

    always_comb begin
        x1_clamp_d = (x1_q > X_MAX) ? X_MAX : x1_q;
        y1_clamp_d = (y1_q > Y_MAX) ? Y_MAX : y1_q;
        // x0/y0 beyond the frame are already caught by the ordering test once
        // the far corner is clamped, but they are kept explicit for clarity.
        rect_bad_d = (x0_q > x1_clamp_d) || (y0_q > y1_clamp_d) ||
                     (x0_q > X_MAX)      || (y0_q > Y_MAX);
        // The only multiply: row offset of the first row. Later rows step by H_RES.
        row_base_d = ADDR_W'(y0_q) * H_STEP;
        next_row_d = row_base_q + H_STEP;
        accept_d   = we_q & mem_ready;
        last_col_d = (cx_q == x1_q);
        last_row_d = (cy_q == y1_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        color_q <= fill_color;
                        if (mode) begin
                            x0_q <= x0;
                            y0_q <= y0;
                            x1_q <= x1;
                            y1_q <= y1;
                        end else begin
                            x0_q <= '0;
                            y0_q <= '0;
                            x1_q <= X_MAX;
                            y1_q <= Y_MAX;
                        end
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end

                CHECK: begin
                    if (rect_bad_d) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        x1_q       <= x1_clamp_d;
                        y1_q       <= y1_clamp_d;
                        cx_q       <= x0_q;
                        cy_q       <= y0_q;
                        row_base_q <= row_base_d;
                        addr_q     <= row_base_d + ADDR_W'(x0_q);
                        wdata_q    <= color_q;
                        we_q       <= 1'b1;
                        state_q    <= FILL;
                    end
                end

                FILL: begin
                    // Outputs simply hold while the memory stalls.
                    if (accept_d) begin
                        if (last_col_d) begin
                            if (last_row_d) begin
                                we_q    <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= FIN;
                            end else begin
                                cx_q       <= x0_q;
                                cy_q       <= cy_q + Y_W'(1);
                                row_base_q <= next_row_d;
                                addr_q     <= next_row_d + ADDR_W'(x0_q);
                            end
                        end else begin
                            cx_q   <= cx_q + X_W'(1);
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end

                FIN: begin
                    // start is deliberately not sampled here.
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign addr  = addr_q;
    assign wdata = wdata_q;
    assign we    = we_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_fb_fill_engine.sv
// -----------------------------------------------------------------------------
// tb_fb_fill_engine
//
// Purpose:
//   Directed self-checking bench for fb_fill_engine. A small 8x4 instance
//   covers full clear, rectangles, stalls, invalid rectangles, ignored starts
//   and mid-operation reset; a default 640x480 instance covers clamping.
// -----------------------------------------------------------------------------
module tb_fb_fill_engine;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_s;
    logic        start_b;
    logic        mode;
    logic [9:0]  x0;
    logic [8:0]  y0;
    logic [9:0]  x1;
    logic [8:0]  y1;
    logic [5:0]  fill_color;
    logic        mem_ready;

    logic [18:0] addr_s, addr_b;
    logic [5:0]  wdata_s, wdata_b;
    logic        we_s, we_b, busy_s, busy_b, done_s, done_b, err_s, err_b;

    fb_fill_engine #(.H_RES(8), .V_RES(4)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .mode(mode),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .fill_color(fill_color),
        .mem_ready(mem_ready), .addr(addr_s), .wdata(wdata_s), .we(we_s),
        .busy(busy_s), .done(done_s), .err(err_s)
    );

    fb_fill_engine dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .fill_color(fill_color),
        .mem_ready(mem_ready), .addr(addr_b), .wdata(wdata_b), .we(we_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Results of the most recent run_op
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          done_cyc;
    int          done_cnt;
    int          hold_bad;
    logic        err_val;
    logic        busy_at[0:511];

    // Starts one operation on the small (big=0) or default (big=1) instance.
    // Cycle k=1 is the cycle after the start edge. Inputs are scrambled after
    // the start edge; restart_k pulses a second start in cycle restart_k.
    task automatic run_op(input bit big, input bit md, input int ax0, input int ay0,
                          input int ax1, input int ay1, input int col,
                          input bit stall, input int restart_k);
        logic        cur_we, cur_done, cur_err, cur_busy;
        logic [31:0] cur_addr, cur_wdata, prev_addr, prev_wdata;
        bit          prev_stall;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc   = -1;
        done_cnt   = 0;
        hold_bad   = 0;
        err_val    = 1'b0;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_wdata = '0;
        @(posedge clk); #1;
        mode       = md;
        x0         = ax0[9:0];
        y0         = ay0[8:0];
        x1         = ax1[9:0];
        y1         = ay1[8:0];
        fill_color = col[5:0];
        mem_ready  = 1'b1;
        if (big) start_b = 1'b1; else start_s = 1'b1;
        @(posedge clk); #1;
        start_s    = 1'b0;
        start_b    = 1'b0;
        mode       = ~md;
        x0         = 10'd0;
        y0         = 9'd0;
        x1         = 10'd1023;
        y1         = 9'd511;
        fill_color = ~fill_color;
        for (int k = 1; k <= 400; k++) begin
            mem_ready = stall ? (k % 2 == 0) : 1'b1;
            if (k == restart_k) begin
                mode = 1'b1;
                x0 = 10'd0; y0 = 9'd0; x1 = 10'd0; y1 = 9'd0;
                if (big) start_b = 1'b1; else start_s = 1'b1;
            end else begin
                start_s = 1'b0;
                start_b = 1'b0;
            end
            @(negedge clk);
            cur_we    = big ? we_b : we_s;
            cur_addr  = big ? 32'(addr_b) : 32'(addr_s);
            cur_wdata = big ? 32'(wdata_b) : 32'(wdata_s);
            cur_done  = big ? done_b : done_s;
            cur_err   = big ? err_b : err_s;
            cur_busy  = big ? busy_b : busy_s;
            busy_at[k] = cur_busy;
            if (prev_stall && (cur_we !== 1'b1 || cur_addr !== prev_addr || cur_wdata !== prev_wdata))
                hold_bad++;
            prev_stall = (cur_we === 1'b1) && !mem_ready;
            prev_addr  = cur_addr;
            prev_wdata = cur_wdata;
            if (cur_we === 1'b1 && mem_ready) begin
                wr_addr.push_back(cur_addr);
                wr_data.push_back(cur_wdata);
                wr_cyc.push_back(k);
            end
            if (cur_done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    err_val  = cur_err;
                end
            end
            @(posedge clk); #1;
            if (done_cyc >= 0 && k >= done_cyc + 2) break;
        end
        start_s   = 1'b0;
        start_b   = 1'b0;
        mem_ready = 1'b1;
        check("done_seen", 32'(done_cyc >= 0), 32'd1);
    endtask

    int bad;
    int idx;
    int exp_rect[6] = '{10, 11, 12, 18, 19, 20};

    initial begin
        rst        = 1'b1;
        start_s    = 1'b0;
        start_b    = 1'b0;
        mode       = 1'b0;
        x0         = '0;
        y0         = '0;
        x1         = '0;
        y1         = '0;
        fill_color = '0;
        mem_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr",  32'(addr_s), 32'd0);
        check("rst_wdata", 32'(wdata_s), 32'd0);
        check("rst_ctrl",  {28'd0, we_s, busy_s, done_s, err_s}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full clear, 8x4, colour 0; coordinates are garbage and must be ignored.
        run_op(1'b0, 1'b0, 5, 2, 1, 0, 6'b000000, 1'b0, 0);
        check("clr_count", 32'(wr_addr.size()), 32'd32);
        bad = 0;
        foreach (wr_addr[i]) begin
            if (wr_addr[i] !== 32'(i) || wr_cyc[i] != i + 2 || wr_data[i] !== 32'd0) bad++;
        end
        check("clr_seq", 32'(bad), 32'd0);
        check("clr_done_cyc", 32'(done_cyc), 32'd34);
        check("clr_err", 32'(err_val), 32'd0);
        check("clr_busy_k1", 32'(busy_at[1]), 32'd1);
        check("clr_busy_fin", 32'(busy_at[34]), 32'd0);

        // Rectangle (2,1)-(4,2), colour 110110; a start pulse during FILL is ignored.
        run_op(1'b0, 1'b1, 2, 1, 4, 2, 6'b110110, 1'b0, 3);
        check("rect_count", 32'(wr_addr.size()), 32'd6);
        bad = 0;
        foreach (wr_addr[i]) begin
            if (i < 6 && (wr_addr[i] !== 32'(exp_rect[i]) || wr_data[i] !== 32'd54)) bad++;
        end
        check("rect_seq", 32'(bad), 32'd0);
        check("rect_done_cyc", 32'(done_cyc), 32'd8);
        check("rect_done_cnt", 32'(done_cnt), 32'd1);
        check("rect_idle_after", 32'(busy_at[9]), 32'd0);

        // Same rectangle with mem_ready low every other cycle.
        run_op(1'b0, 1'b1, 2, 1, 4, 2, 6'b110110, 1'b1, 0);
        check("stall_count", 32'(wr_addr.size()), 32'd6);
        bad = 0;
        foreach (wr_addr[i]) begin
            if (i < 6 && (wr_addr[i] !== 32'(exp_rect[i]) || wr_data[i] !== 32'd54)) bad++;
        end
        check("stall_seq", 32'(bad), 32'd0);
        check("stall_hold", 32'(hold_bad), 32'd0);
        check("stall_done_cyc", 32'(done_cyc), 32'd13);
        check("stall_done_cnt", 32'(done_cnt), 32'd1);

        // Clamping on the default 640x480 instance: 10x10 pixels.
        run_op(1'b1, 1'b1, 630, 470, 700, 500, 6'b101010, 1'b0, 0);
        check("clamp_count", 32'(wr_addr.size()), 32'd100);
        bad = 0;
        idx = 0;
        for (int yy = 470; yy <= 479; yy++) begin
            for (int xx = 630; xx <= 639; xx++) begin
                if (idx < wr_addr.size() && wr_addr[idx] !== 32'(yy * 640 + xx)) bad++;
                idx++;
            end
        end
        check("clamp_seq", 32'(bad), 32'd0);
        if (wr_addr.size() > 0)
            check("clamp_last", wr_addr[wr_addr.size() - 1], 32'd307199);
        else
            check("clamp_last", 32'hFFFF_FFFF, 32'd307199);
        check("clamp_done_cyc", 32'(done_cyc), 32'd102);
        check("clamp_err", 32'(err_val), 32'd0);

        // Invalid rectangle; a start in the FIN cycle must be ignored.
        run_op(1'b0, 1'b1, 5, 0, 3, 0, 6'b111111, 1'b0, 2);
        check("inv_writes", 32'(wr_addr.size()), 32'd0);
        check("inv_done_cyc", 32'(done_cyc), 32'd2);
        check("inv_err", 32'(err_val), 32'd1);
        check("inv_busy_k1", 32'(busy_at[1]), 32'd1);
        check("inv_fin_start_ignored", {30'd0, busy_at[3], busy_at[4]}, 32'd0);

        // Single-pixel rectangle at the bottom-right corner.
        run_op(1'b0, 1'b1, 7, 3, 7, 3, 6'b010101, 1'b0, 0);
        check("pix_count", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() > 0)
            check("pix_addr", wr_addr[0], 32'd31);
        else
            check("pix_addr", 32'hFFFF_FFFF, 32'd31);
        check("pix_done_cyc", 32'(done_cyc), 32'd3);

        // Reset during the third write of a full clear.
        @(posedge clk); #1;
        mode    = 1'b0;
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rstmid_third_addr", 32'(addr_s), 32'd2);
        check("rstmid_third_we", 32'(we_s), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_ctrl", {29'd0, we_s, busy_s, done_s}, 32'd0);
        run_op(1'b0, 1'b0, 0, 0, 0, 0, 6'b000011, 1'b0, 0);
        check("rstmid_restart_count", 32'(wr_addr.size()), 32'd32);
        if (wr_addr.size() > 0)
            check("rstmid_restart_first", wr_addr[0], 32'd0);
        else
            check("rstmid_restart_first", 32'hFFFF_FFFF, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_fill_engine.md
Name: fb_fill_engine

Overview:
- Parametrised framebuffer / Z-buffer fill engine. Successor to the fixed 640x480 full-screen clear block.
- Writes a latched fill colour either over the whole frame or over a clamped rectangle. Address is linear, row-major: y*H_RES + x.
- Honours a memory-ready stall, uses a start/busy/done handshake, and flags invalid rectangles.
- Sits between the GPU command sequencer and the frame/depth memory write port.

Parameters:
- H_RES, 640, horizontal resolution in pixels.
- V_RES, 480, vertical resolution in pixels.
- X_W, 10, width of x coordinates; requires 2^X_W >= H_RES.
- Y_W, 9, width of y coordinates; requires 2^Y_W >= V_RES.
- ADDR_W, 19, memory address width; requires 2^ADDR_W >= H_RES*V_RES.
- N_CH, 3, number of colour channels.
- CH_BITS, 2, bits per channel.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = full-frame clear, 1 = rectangle fill.
- x0  in  X_W  rectangle left (inclusive).
- y0  in  Y_W  rectangle top (inclusive).
- x1  in  X_W  rectangle right (inclusive).
- y1  in  Y_W  rectangle bottom (inclusive).
- fill_color  in  N_CH*CH_BITS  fill value; channel 0 in the LSBs.
- mem_ready  in  1  memory accepts a write this cycle when high.
- addr  out  ADDR_W  write address.
- wdata  out  N_CH*CH_BITS  write data.
- we  out  1  write strobe.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with done when the rectangle is invalid.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state <= IDLE.
  - addr, wdata = 0; we, busy, done, err = 0.
  - Applies mid-operation: remaining writes are abandoned and we is low from the next cycle.
- States: IDLE, CHECK, FILL, FIN.
- IDLE:
  - On start=1, latch mode, coordinates and fill_color, then go to CHECK.
  - mode=0 replaces the coordinates with (0, 0, H_RES-1, V_RES-1).
- CHECK (1 cycle, busy=1):
  - Clamp x1 to H_RES-1 and y1 to V_RES-1.
  - If x0>x1 or y0>y1 after clamping, or x0>=H_RES, or y0>=V_RES: go to FIN with the error flag set.
  - Otherwise set the cursor to (x0, y0), compute row_base = y0*H_RES, and go to FILL.
  - Multiplication is done once here; the per-row update is row_base += H_RES.
- FILL:
  - Outputs: we=1, addr=row_base+cx, wdata=latched colour.
  - A write is accepted when we & mem_ready.
  - On accept, advance the cursor: cx++. At cx==x1, set cx=x0, increment cy, and add H_RES to row_base.
  - Accepting the write at (x1, y1) moves to FIN.
  - While mem_ready=0, addr, wdata and we=1 hold stable.
- FIN (1 cycle):
  - we=0, busy=0, done=1; err=1 if the error flag is set.
  - Returns to IDLE.
- Timing:
  - start at edge T leads to CHECK in cycle T+1.
  - First write is presented in cycle T+2.
  - With mem_ready held high, N writes occupy T+2 .. T+N+1 and done appears in T+N+2.
- Simultaneous and edge events:
  - start while not IDLE is ignored, with no queueing.
  - start in the FIN cycle is ignored.
  - Changes to input coordinates or colour after latching have no effect.
  - A single-pixel rectangle gives exactly one write.
  - Arithmetic sizing: addr max = H_RES*V_RES-1; row_base is ADDR_W wide; no wrap occurs within legal parameters.

Test Plan:
- Full clear, H_RES=8, V_RES=4, fill_color=6'b000000, mem_ready=1 -> 32 writes, addr 0..31 in consecutive cycles, done in cycle T+34, err=0.
- Rectangle mode, H_RES=8, V_RES=4, (x0,y0,x1,y1)=(2,1,4,2), fill_color=6'b110110 -> 6 writes, addr 10,11,12,18,19,20, wdata=6'b110110 each.
- Same rectangle with mem_ready low on every other cycle -> addr/wdata/we held during stalls, same 6 addresses in order, done once after the last accepted write.
- Clamping, default params, rect (630,470,700,500) -> 10x10 = 100 writes; last addr = 479*640+639 = 307199.
- Invalid rect (5,0,3,0) -> no we, done and err both pulse in cycle T+2; start during busy is ignored.
- rst asserted during the 3rd write of a full clear -> next cycle we=0, busy=0, done=0; a new start then restarts at addr 0.
